// File: rtl/ysyx_22040237_wb_arb.sv
// Register-file write-back arbiter: merges execute results (src0) with buffered LSU/MDU results (src1).
// One registered write per cycle; a starved src1 FIFO head forces priority for one pop.
module ysyx_22040237_wb_arb #(
  parameter int DW         = 64,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s0_valid,
  output logic                     s0_ready,
  input  logic [AW-1:0]            s0_addr,
  input  logic [DW-1:0]            s0_data,
  input  logic                     s1_valid,
  output logic                     s1_ready,
  input  logic [AW-1:0]            s1_addr,
  input  logic [DW-1:0]            s1_data,
  output logic                     reg_wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            q_addr1,
  input  logic [AW-1:0]            q_addr2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;

  logic empty, force_s1, sel_s0, pop, push;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign empty     = (cnt == '0);
  assign force_s1  = !empty && (starve == SMAX);
  assign s0_ready  = !force_s1;
  assign s1_ready  = (cnt != FULL_CNT);
  assign sel_s0    = s0_valid && !force_s1;
  assign pop       = !sel_s0 && !empty;
  assign push      = s1_valid && s1_ready;
  assign head_addr = mem_addr[head];
  assign head_data = mem_data[head];
  assign fifo_cnt  = cnt;

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= s1_addr;
      mem_data[tail] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      starve <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (empty || pop)
        starve <= '0;
      else if (sel_s0 && starve != SMAX)
        starve <= starve + 1'b1;
    end
  end

  // x0 destinations still complete their handshake but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_en <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (sel_s0) begin
      reg_wr_en <= (s0_addr != '0);
      wr_addr   <= s0_addr;
      wr_data   <= s0_data;
    end else if (pop) begin
      reg_wr_en <= (head_addr != '0);
      wr_addr   <= head_addr;
      wr_data   <= head_data;
    end else begin
      reg_wr_en <= 1'b0;
    end
  end

  logic          hit1, hit2;
  logic [PW-1:0] idx;

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < cnt) begin
        if (mem_addr[idx] == q_addr1) hit1 = 1'b1;
        if (mem_addr[idx] == q_addr2) hit2 = 1'b1;
      end
    end
  end

  assign hazard1 = (q_addr1 != '0) && (hit1 || (reg_wr_en && wr_addr == q_addr1));
  assign hazard2 = (q_addr2 != '0) && (hit2 || (reg_wr_en && wr_addr == q_addr2));

endmodule
